// File: rtl/alu_pkg.sv
// Shared opcodes, FSM states and flag indices for the handshaked ALU.
// Used by alu_seq and, with ALU_MDU_EN, by mdu_iter.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_MULH = 4'b1011;
  localparam logic [3:0] OP_DIVU = 4'b1100;
  localparam logic [3:0] OP_REMU = 4'b1101;

  localparam int FR_ZF = 3;
  localparam int FR_SF = 2;
  localparam int FR_CF = 1;
  localparam int FR_OF = 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  // 1010..1101 are the iterative ops
  function automatic logic is_mdu(input logic [3:0] op);
    return op[3] & (op[2] ^ op[1]);
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative shift-add multiplier / restoring divider, one step per cycle.
// Accumulator {hi,lo}: MUL/MULHU or quotient/remainder after XLEN steps.
module mdu_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_clr,
  input  logic            i_start,
  input  logic            i_div,
  input  logic            i_hi,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_done,
  output logic [XLEN-1:0] o_res
);

  localparam int CW = $clog2(XLEN);

  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_b;
  logic              r_div;
  logic              r_hi;
  logic              r_busy;
  logic              r_done;
  logic [CW-1:0]     r_cnt;

  logic [XLEN:0]     w_sum;
  logic [XLEN:0]     w_rem;
  logic [XLEN-1:0]   w_dif;
  logic              w_ge;
  logic [2*XLEN-1:0] w_next;
  logic              w_last;

  always_comb begin
    w_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_b};
    w_rem  = r_acc[2*XLEN-1:XLEN-1];
    w_ge   = (w_rem >= {1'b0, r_b});
    w_dif  = w_rem[XLEN-1:0] - r_b;
    w_next = {1'b0, r_acc[2*XLEN-1:1]};
    if (r_div) begin
      if (w_ge) w_next = {w_dif, r_acc[XLEN-2:0], 1'b1};
      else      w_next = {r_acc[2*XLEN-2:0], 1'b0};
    end else if (r_acc[0]) begin
      w_next = {w_sum, r_acc[XLEN-1:1]};
    end
  end

  assign w_last = r_busy && (r_cnt == CW'(XLEN-1));
  assign o_done = r_done;
  assign o_res  = r_hi ? r_acc[2*XLEN-1:XLEN] : r_acc[XLEN-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_b    <= '0;
      r_div  <= 1'b0;
      r_hi   <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_cnt  <= '0;
    end else if (i_clr) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_cnt  <= '0;
    end else if (i_start) begin
      r_acc  <= {{XLEN{1'b0}}, i_a};
      r_b    <= i_b;
      r_div  <= i_div;
      r_hi   <= i_hi;
      r_busy <= 1'b1;
      r_done <= 1'b0;
      r_cnt  <= '0;
    end else if (r_busy) begin
      r_acc  <= w_next;
      r_done <= w_last;
      r_busy <= !w_last;
      r_cnt  <= w_last ? '0 : r_cnt + 1'b1;
    end else begin
      r_done <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked RV32I ALU with registered result; optional iterative MUL/DIV.
// Define ALU_MDU_EN to build mdu_iter and enable opcodes 1010..1101.
module alu_seq
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] alu_a,
  input  logic [XLEN-1:0] alu_b,
  input  logic [3:0]      alu_op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_f,
  output logic [3:0]      fr,
  output logic            op_err
);

  localparam int M = XLEN - 1;

  state_t          r_state;
  logic [XLEN-1:0] r_f;
  logic [3:0]      r_fr;
  logic            r_err;

  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_dif;
  logic [SHW-1:0]  w_sh;
  logic [XLEN-1:0] w_res;
  logic            w_cf;
  logic            w_of;
  logic            w_err;
  logic            w_acc;
  logic            w_go_busy;

  assign w_acc = in_valid && (r_state == S_IDLE);

  always_comb begin
    w_sum = {1'b0, alu_a} + {1'b0, alu_b};
    w_dif = {1'b0, alu_a} - {1'b0, alu_b};
    w_sh  = alu_b[SHW-1:0];
    w_res = '0;
    w_cf  = 1'b0;
    w_of  = 1'b0;
    w_err = 1'b0;
    case (alu_op)
      OP_ADD: begin
        w_res = w_sum[M:0];
        w_cf  = w_sum[XLEN];
        w_of  = (alu_a[M] == alu_b[M]) && (w_sum[M] != alu_a[M]);
      end
      OP_SUB: begin
        w_res = w_dif[M:0];
        w_cf  = w_dif[XLEN];
        w_of  = (alu_a[M] != alu_b[M]) && (w_dif[M] != alu_a[M]);
      end
      OP_SLL:  w_res = alu_a << w_sh;
      OP_SRL:  w_res = alu_a >> w_sh;
      OP_SRA:  w_res = $signed(alu_a) >>> w_sh;
      OP_SLT:  w_res = {{M{1'b0}}, $signed(alu_a) < $signed(alu_b)};
      OP_SLTU: w_res = {{M{1'b0}}, alu_a < alu_b};
      OP_XOR:  w_res = alu_a ^ alu_b;
      OP_OR:   w_res = alu_a | alu_b;
      OP_AND:  w_res = alu_a & alu_b;
      default: w_err = 1'b1;
    endcase
  end

`ifdef ALU_MDU_EN
  logic            w_mdu_done;
  logic [XLEN-1:0] w_mres;

  assign w_go_busy = is_mdu(alu_op);

  mdu_iter #(.XLEN(XLEN)) u_mdu (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (flush),
    .i_start (w_acc && w_go_busy && !flush),
    .i_div   (alu_op[2]),
    .i_hi    (alu_op[0]),
    .i_a     (alu_a),
    .i_b     (alu_b),
    .o_done  (w_mdu_done),
    .o_res   (w_mres)
  );
`else
  assign w_go_busy = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_f     <= '0;
      r_fr    <= '0;
      r_err   <= 1'b0;
    end else if (flush) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_acc && w_go_busy) begin
            r_state <= S_BUSY;
          end else if (w_acc) begin
            r_state <= S_DONE;
            r_f     <= w_res;
            r_fr    <= {w_res == '0, w_res[M], w_cf, w_of};
            r_err   <= w_err;
          end
        end
        S_BUSY: begin
`ifdef ALU_MDU_EN
          if (w_mdu_done) begin
            r_state <= S_DONE;
            r_f     <= w_mres;
            r_fr    <= {w_mres == '0, w_mres[M], 2'b00};
            r_err   <= 1'b0;
          end
`else
          r_state <= S_IDLE;
`endif
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign alu_f     = r_f;
  assign fr        = r_fr;
  assign op_err    = r_err;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (XLEN = 32).
// MUL/DIV expectations follow the ALU_MDU_EN build setting.
module tb_alu_seq;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_f;
  logic [3:0]  fr;
  logic        op_err;

  int nvec = 0;
  int nerr = 0;

  alu_seq #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_f     (alu_f),
    .fr        (fr),
    .op_err    (op_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef ALU_MDU_EN
  localparam int MLAT = 33;
`else
  localparam int MLAT = 1;
`endif

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run(input string tag, input logic [3:0] op,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] ef, input logic [3:0] efr,
                     input logic eerr, input int lat);
    int n;
    @(negedge clk);
    chk({tag, " in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    alu_op   = op;
    alu_a    = a;
    alu_b    = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    alu_a    = ~a;
    alu_b    = ~b;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 200);
    chk({tag, " latency"}, 64'(n), 64'(lat));
    chk({tag, " alu_f"}, 64'(alu_f), 64'(ef));
    chk({tag, " fr"}, 64'(fr), 64'(efr));
    chk({tag, " op_err"}, 64'(op_err), 64'(eerr));
  endtask

  initial begin
    int seen;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    alu_a     = '0;
    alu_b     = '0;
    alu_op    = '0;
    repeat (2) @(negedge clk);
    chk("rst in_ready", 64'(in_ready), 64'd1);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst alu_f", 64'(alu_f), 64'd0);
    chk("rst fr", 64'(fr), 64'd0);
    chk("rst op_err", 64'(op_err), 64'd0);
    rst_n = 1'b1;

    run("add ovf", 4'b0000, 32'h7FFFFFFF, 32'h1, 32'h80000000, 4'b0101, 0, 1);
    run("add cy", 4'b0000, 32'hFFFFFFFF, 32'h1, 32'h0, 4'b1010, 0, 1);
    run("sub", 4'b1000, 32'h0, 32'h1, 32'hFFFFFFFF, 4'b0110, 0, 1);
    run("sub ovf", 4'b1000, 32'h80000000, 32'h1, 32'h7FFFFFFF, 4'b0001, 0, 1);
    run("sra", 4'b1001, 32'h80000000, 32'd33, 32'hC0000000, 4'b0100, 0, 1);
    run("sll", 4'b0001, 32'h1, 32'd31, 32'h80000000, 4'b0100, 0, 1);
    run("srl", 4'b0101, 32'h80000000, 32'd36, 32'h08000000, 4'b0000, 0, 1);
    run("slt", 4'b0010, 32'hFFFFFFFF, 32'h1, 32'h1, 4'b0000, 0, 1);
    run("sltu", 4'b0011, 32'hFFFFFFFF, 32'h1, 32'h0, 4'b1000, 0, 1);
    run("xor", 4'b0100, 32'hF0F0, 32'h0FF0, 32'hFF00, 4'b0000, 0, 1);
    run("or", 4'b0110, 32'hF000_0000, 32'h0F, 32'hF000000F, 4'b0100, 0, 1);
    run("and", 4'b0111, 32'h0F0F, 32'hF0F0, 32'h0, 4'b1000, 0, 1);
    run("illegal", 4'b1110, 32'h5, 32'h6, 32'h0, 4'b1000, 1, 1);

`ifdef ALU_MDU_EN
    run("divu", 4'b1100, 32'd100, 32'd7, 32'd14, 4'b0000, 0, MLAT);
    run("remu", 4'b1101, 32'd100, 32'd7, 32'd2, 4'b0000, 0, MLAT);
    run("divu0", 4'b1100, 32'h12345678, 32'h0, 32'hFFFFFFFF, 4'b0100, 0, MLAT);
    run("remu0", 4'b1101, 32'd5, 32'h0, 32'd5, 4'b0000, 0, MLAT);
    run("mulhu", 4'b1011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 4'b0100, 0, MLAT);
    run("mul", 4'b1010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 4'b0000, 0, MLAT);
`else
    run("mul ill", 4'b1010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 4'b1000, 1, MLAT);
    run("mulhu ill", 4'b1011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 4'b1000, 1, MLAT);
    run("divu ill", 4'b1100, 32'd100, 32'd7, 32'h0, 4'b1000, 1, MLAT);
    run("remu ill", 4'b1101, 32'd100, 32'd7, 32'h0, 4'b1000, 1, MLAT);
`endif

    // Hold the result for 5 cycles while a new request is presented
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    alu_op    = 4'b0000;
    alu_a     = 32'd2;
    alu_b     = 32'd3;
    @(posedge clk);
    #1;
    alu_a = 32'd9;
    alu_b = 32'd9;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold out_valid", 64'(out_valid), 64'd1);
      chk("hold in_ready", 64'(in_ready), 64'd0);
      chk("hold alu_f", 64'(alu_f), 64'd5);
      chk("hold fr", 64'(fr), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("release out_valid", 64'(out_valid), 64'd0);
    chk("release in_ready", 64'(in_ready), 64'd1);
    chk("release alu_f", 64'(alu_f), 64'd5);

    // Back-to-back: second op accepted two edges after the first
    @(negedge clk);
    in_valid = 1'b1;
    alu_op   = 4'b0000;
    alu_a    = 32'd10;
    alu_b    = 32'd20;
    @(negedge clk);
    chk("b2b first", 64'(alu_f), 64'd30);
    alu_a = 32'd40;
    @(negedge clk);
    chk("b2b gap in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b second", 64'(alu_f), 64'd60);
    chk("b2b second valid", 64'(out_valid), 64'd1);

    // Flush an in-flight op
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
`ifdef ALU_MDU_EN
    alu_op = 4'b1100;
`else
    alu_op = 4'b0000;
`endif
    alu_a = 32'd100;
    alu_b = 32'd7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
`ifdef ALU_MDU_EN
    repeat (10) @(negedge clk);
    chk("busy in_ready", 64'(in_ready), 64'd0);
`else
    @(negedge clk);
`endif
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush     = 1'b0;
    out_ready = 1'b1;
    chk("flush out_valid", 64'(out_valid), 64'd0);
    chk("flush in_ready", 64'(in_ready), 64'd1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("flush quiet", 64'(seen), 64'd0);
    run("post flush", 4'b0000, 32'd2, 32'd3, 32'd5, 4'b0000, 0, 1);

    // Asynchronous reset in the middle of an op
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
`ifdef ALU_MDU_EN
    alu_op = 4'b1010;
`else
    alu_op = 4'b0000;
`endif
    alu_a = 32'd6;
    alu_b = 32'd7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst out_valid", 64'(out_valid), 64'd0);
    chk("arst in_ready", 64'(in_ready), 64'd1);
    chk("arst alu_f", 64'(alu_f), 64'd0);
    chk("arst fr", 64'(fr), 64'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("arst quiet", 64'(seen), 64'd0);
    run("post rst", 4'b0000, 32'd2, 32'd3, 32'd5, 4'b0000, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
